// File: rtl/cam_rgb565_packer.sv
// Pairs RGB565 camera bytes into remapped 16-bit pixels, checks line/frame geometry, skips settling frames.
// Latency: pixel registered one cycle after its lo byte; no backpressure, camera bytes cannot be stalled.
module cam_rgb565_packer #(
    parameter int H_PIXELS    = 640,
    parameter int V_LINES     = 480,
    parameter int SKIP_FRAMES = 2
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Vsync,
    input  logic        Href,
    input  logic        En_In,
    input  logic [7:0]  Data_In,
    output logic        En_Out,
    output logic [15:0] Data_Out,
    output logic        Frame_Start,
    output logic        Frame_Done,
    output logic        Err
);
    localparam int PW = (H_PIXELS < 1) ? 1 : $clog2(H_PIXELS + 1);
    localparam int LW = (V_LINES < 1) ? 1 : $clog2(V_LINES + 1);
    localparam int SW = (SKIP_FRAMES < 1) ? 1 : $clog2(SKIP_FRAMES + 1);
    localparam logic [PW-1:0] H_MAX = PW'(H_PIXELS);
    localparam logic [LW-1:0] V_MAX = LW'(V_LINES);
    localparam logic [SW-1:0] S_MAX = SW'(SKIP_FRAMES);

    typedef enum logic {IDLE, FRAME} state_t;

    state_t          state, state_nxt;
    logic            vsync_d, href_d, phase, in_frame;
    logic [7:0]      hi_byte;
    logic [PW-1:0]   pix_cnt;
    logic [LW-1:0]   line_cnt, line_inc;
    logic [SW-1:0]   skip_cnt;
    logic            vs_rise, href_fall, in_fr_state;
    logic            byte_vld, byte_ok, emit, line_end;
    logic            frame_short, frame_full, err_set;

    always_comb begin
        vs_rise     = Vsync & ~vsync_d;
        href_fall   = ~Href & href_d;
        in_fr_state = (state == FRAME);
        byte_vld    = in_fr_state & En_In & Href & ~Vsync;
        byte_ok     = byte_vld & (line_cnt < V_MAX);
        emit        = byte_ok & phase & (pix_cnt != H_MAX);
        // Line bookkeeping runs on every Href fall, even while Vsync is high.
        line_end    = in_fr_state & href_fall;
        line_inc    = line_cnt + 1'b1;
        frame_short = in_fr_state & vs_rise & in_frame & (line_cnt != V_MAX);
        frame_full  = line_end & (pix_cnt != '0) & (line_inc == V_MAX);
        err_set     = (byte_vld & ~byte_ok)
                    | (byte_ok & phase & (pix_cnt == H_MAX))
                    | (line_end & (phase | (pix_cnt != H_MAX)))
                    | frame_short;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (vs_rise && skip_cnt == S_MAX) state_nxt = FRAME;
            FRAME:   state_nxt = FRAME;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            vsync_d     <= 1'b0;
            href_d      <= 1'b0;
            phase       <= 1'b0;
            in_frame    <= 1'b0;
            hi_byte     <= 8'h00;
            pix_cnt     <= '0;
            line_cnt    <= '0;
            skip_cnt    <= '0;
            En_Out      <= 1'b0;
            Data_Out    <= 16'h0000;
            Frame_Start <= 1'b0;
            Frame_Done  <= 1'b0;
            Err         <= 1'b0;
        end else begin
            vsync_d     <= Vsync;
            href_d      <= Href;
            En_Out      <= emit;
            Frame_Start <= emit & (pix_cnt == '0) & (line_cnt == '0);
            Frame_Done  <= frame_short | frame_full;
            if (emit)
                Data_Out <= {Data_In[4:0], hi_byte[2:0], Data_In[7:5], hi_byte[7:3]};
            // A new error in the boundary cycle outranks the Vsync clear.
            if (err_set)
                Err <= 1'b1;
            else if (in_fr_state && vs_rise)
                Err <= 1'b0;

            if (!in_fr_state) begin
                if (vs_rise) begin
                    if (skip_cnt != S_MAX) skip_cnt <= skip_cnt + 1'b1;
                    phase    <= 1'b0;
                    pix_cnt  <= '0;
                    line_cnt <= '0;
                    in_frame <= 1'b0;
                end
            end else begin
                if (byte_ok) begin
                    phase    <= ~phase;
                    in_frame <= 1'b1;
                    if (!phase) hi_byte <= Data_In;
                    if (emit)   pix_cnt <= pix_cnt + 1'b1;
                end
                if (line_end) begin
                    phase   <= 1'b0;
                    pix_cnt <= '0;
                    if (pix_cnt != '0) line_cnt <= line_inc;
                end
                if (vs_rise) begin
                    phase    <= 1'b0;
                    pix_cnt  <= '0;
                    line_cnt <= '0;
                    in_frame <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_cam_rgb565_packer.sv
// Drives random camera frames into two packers (no skip / two skipped frames) and
// compares every output cycle against a frame/line-level reference model.
module tb_cam_rgb565_packer;
    localparam int H = 4;
    localparam int V = 2;

    typedef logic [7:0] bq_t [$];
    typedef struct {
        int          cyc;
        logic [15:0] dat;
        logic        fs;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vsync = 1'b0;
    logic        href = 1'b0;
    logic        en_in = 1'b0;
    logic [7:0]  data_in = 8'h00;
    logic [1:0]  en_out, frame_start, frame_done, err;
    logic [15:0] data_out [2];

    cam_rgb565_packer #(.H_PIXELS(H), .V_LINES(V), .SKIP_FRAMES(0)) dut_s0 (
        .Clock(clk), .Reset(rst), .Vsync(vsync), .Href(href), .En_In(en_in),
        .Data_In(data_in), .En_Out(en_out[0]), .Data_Out(data_out[0]),
        .Frame_Start(frame_start[0]), .Frame_Done(frame_done[0]), .Err(err[0]));

    cam_rgb565_packer #(.H_PIXELS(H), .V_LINES(V), .SKIP_FRAMES(2)) dut_s2 (
        .Clock(clk), .Reset(rst), .Vsync(vsync), .Href(href), .En_In(en_in),
        .Data_In(data_in), .En_Out(en_out[1]), .Data_Out(data_out[1]),
        .Frame_Start(frame_start[1]), .Frame_Done(frame_done[1]), .Err(err[1]));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic mon_on = 1'b0;

    // Reference model state, one slot per instance.
    int          skip_frames [2] = '{0, 2};
    int          armed [2], skip_seen [2], line_m [2], in_fr [2];
    int          err_m [2], done_m [2], done_seen [2], pix_m [2], nb_m [2];
    logic [7:0]  hi_m [2];
    logic [15:0] last_dat [2];
    exp_t        exp_q [2][$];
    logic [15:0] obs_q [2][$];
    int          len_tab [10] = '{8, 8, 8, 8, 8, 6, 9, 10, 7, 2};

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] pack_pixel(input logic [7:0] hi, input logic [7:0] lo);
        int r, g, b;
        r = int'(hi) / 8;
        g = (int'(hi) % 8) * 8 + int'(lo) / 32;
        b = int'(lo) % 32;
        return 16'(r + g * 32 + b * 2048);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    exp_t mon_cur;
    logic mon_hit;
    always @(negedge clk) begin
        if (mon_on) begin
            for (int k = 0; k < 2; k++) begin
                while (exp_q[k].size() > 0 && exp_q[k][0].cyc < cyc)
                    void'(exp_q[k].pop_front());
                mon_hit = (exp_q[k].size() > 0) && (exp_q[k][0].cyc == cyc);
                chk($sformatf("en_out%0d", k), en_out[k], mon_hit);
                if (mon_hit) begin
                    mon_cur = exp_q[k].pop_front();
                    last_dat[k] = mon_cur.dat;
                    chk($sformatf("frame_start%0d", k), frame_start[k], mon_cur.fs);
                end else begin
                    chk($sformatf("frame_start%0d", k), frame_start[k], 1'b0);
                end
                chk($sformatf("data_out%0d", k), data_out[k], last_dat[k]);
                if (en_out[k]) obs_q[k].push_back(data_out[k]);
                if (frame_done[k]) done_seen[k]++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkpoint(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_err%0d", tag, k), err[k], err_m[k]);
            chk($sformatf("%s_done%0d", tag, k), done_seen[k], done_m[k]);
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            if (armed[k] != 0) begin
                if (line_m[k] >= V) begin
                    err_m[k] = 1;
                end else begin
                    in_fr[k] = 1;
                    if (nb_m[k] % 2 == 0) begin
                        hi_m[k] = b;
                    end else if (pix_m[k] < H) begin
                        e.cyc = cyc + 1;
                        e.dat = pack_pixel(hi_m[k], b);
                        e.fs  = (pix_m[k] == 0) && (line_m[k] == 0);
                        exp_q[k].push_back(e);
                        pix_m[k]++;
                    end else begin
                        err_m[k] = 1;
                    end
                    nb_m[k]++;
                end
            end
        end
    endtask

    task automatic model_line_end();
        for (int k = 0; k < 2; k++) begin
            if (armed[k] != 0) begin
                if (nb_m[k] % 2 == 1) err_m[k] = 1;
                if (pix_m[k] != H)    err_m[k] = 1;
                if (pix_m[k] > 0) begin
                    line_m[k]++;
                    if (line_m[k] == V) done_m[k]++;
                end
            end
        end
    endtask

    task automatic model_vsync();
        for (int k = 0; k < 2; k++) begin
            if (armed[k] == 0) begin
                if (skip_seen[k] == skip_frames[k]) armed[k] = 1;
                else skip_seen[k]++;
            end else begin
                if (in_fr[k] != 0 && line_m[k] != V) begin
                    done_m[k]++;
                    err_m[k] = 1;
                end else begin
                    err_m[k] = 0;
                end
            end
            line_m[k] = 0;
            in_fr[k]  = 0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int g;
        g = int'($urandom_range(0, 2));
        repeat (g) begin
            tick();
            en_in   = 1'b0;
            data_in = 8'($urandom);
        end
        tick();
        en_in   = 1'b1;
        data_in = b;
        model_byte(b);
    endtask

    task automatic line_begin();
        tick();
        href  = 1'b1;
        en_in = 1'b0;
        for (int k = 0; k < 2; k++) begin
            pix_m[k] = 0;
            nb_m[k]  = 0;
        end
    endtask

    task automatic line_finish();
        tick();
        en_in = 1'b0;
        tick();
        href = 1'b0;
        repeat (3) tick();
        model_line_end();
        checkpoint("line");
    endtask

    task automatic send_line(input bq_t bs);
        line_begin();
        foreach (bs[i]) send_byte(bs[i]);
        line_finish();
    endtask

    task automatic vsync_pulse();
        tick();
        vsync = 1'b1;
        model_vsync();
        repeat (3) tick();
        vsync = 1'b0;
        repeat (3) tick();
        checkpoint("vsync");
    endtask

    task automatic rand_frame();
        int r, nl, n;
        bq_t bs;
        vsync_pulse();
        r  = int'($urandom_range(0, 9));
        nl = (r < 7) ? V : (r == 7) ? V - 1 : (r == 8) ? V + 1 : 0;
        repeat (nl) begin
            n = len_tab[int'($urandom_range(0, 9))];
            bs.delete();
            for (int i = 0; i < n; i++) bs.push_back(8'($urandom));
            send_line(bs);
        end
    endtask

    task automatic do_reset();
        mon_on = 1'b0;
        rst    = 1'b1;
        en_in  = 1'b0;
        repeat (2) tick();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_en_out%0d", k), en_out[k], 1'b0);
            chk($sformatf("rst_data_out%0d", k), data_out[k], 16'h0000);
            chk($sformatf("rst_frame_start%0d", k), frame_start[k], 1'b0);
            chk($sformatf("rst_frame_done%0d", k), frame_done[k], 1'b0);
            chk($sformatf("rst_err%0d", k), err[k], 1'b0);
            exp_q[k].delete();
            last_dat[k]  = 16'h0000;
            armed[k]     = 0;
            skip_seen[k] = 0;
            line_m[k]    = 0;
            in_fr[k]     = 0;
            err_m[k]     = 0;
            pix_m[k]     = 0;
            nb_m[k]      = 0;
        end
        rst    = 1'b0;
        mon_on = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bq_t colour, bs;
        for (int k = 0; k < 2; k++) begin
            done_m[k]    = 0;
            done_seen[k] = 0;
        end
        do_reset();

        // Pure red, green and blue first: only the no-skip instance is armed.
        vsync_pulse();
        obs_q[0].delete();
        colour = {8'hF8, 8'h00, 8'h07, 8'hE0, 8'h00, 8'h1F, 8'h12, 8'h34};
        send_line(colour);
        chk("colour_count", obs_q[0].size(), 4);
        if (obs_q[0].size() >= 3) begin
            chk("colour_red",   obs_q[0][0], 16'h001F);
            chk("colour_green", obs_q[0][1], 16'h07E0);
            chk("colour_blue",  obs_q[0][2], 16'hF800);
        end
        chk("skip_inst_quiet", obs_q[1].size(), 0);
        for (int i = 0; i < 2 * H; i++) bs.push_back(8'($urandom));
        send_line(bs);

        repeat (14) rand_frame();

        // Reset lands between the hi and lo byte of a pixel.
        vsync_pulse();
        line_begin();
        send_byte(8'hA5);
        tick();
        en_in = 1'b0;
        do_reset();
        obs_q[0].delete();
        obs_q[1].delete();
        send_byte(8'h5A);
        line_finish();
        chk("post_reset_no_pixel0", obs_q[0].size(), 0);
        chk("post_reset_no_pixel1", obs_q[1].size(), 0);

        repeat (6) rand_frame();
        vsync_pulse();
        repeat (5) tick();
        chk("drain0", exp_q[0].size(), 0);
        chk("drain1", exp_q[1].size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cam_rgb565_packer.md
# cam_rgb565_packer

Camera-side pixel assembler feeding the grayscale/JPEG front end. Accepts the 8-bit DVP byte stream of an RGB565 camera (already synchronised to the system clock, one strobe per byte), pairs bytes into 16-bit pixels, and re-orders the fields into the front end's pixel layout R[4:0], G[10:5], B[15:11]. Also tracks line/frame geometry, skips the first frames after reset while the sensor settles, and flags malformed frames.

## Interface

- H_PIXELS, 640: pixels per active line.
- V_LINES, 480: active lines per frame.
- SKIP_FRAMES, 2: frames discarded after reset (0 = none).

- Clock  in  1  system clock; all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Vsync  in  1  high during vertical blanking; rising edge = frame boundary.
- Href  in  1  high while active line bytes are presented.
- En_In  in  1  byte strobe; byte accepted when En_In & Href & ~Vsync in state FRAME.
- Data_In  in  8  camera byte.
- En_Out  out  1  one-cycle pixel strobe.
- Data_Out  out  16  pixel: R[4:0], G[10:5], B[15:11]; holds last value between strobes.
- Frame_Start  out  1  high with En_Out of first pixel of each frame.
- Frame_Done  out  1  one-cycle pulse at frame end.
- Err  out  1  sticky frame-error flag.

## Operation

- States: IDLE (counting skip frames), FRAME (accepting bytes).
- Vsync/Href edges detected against one-cycle-registered copies.
- IDLE: each Vsync rise increments skip_cnt; Vsync rise with skip_cnt == SKIP_FRAMES -> FRAME, counters cleared. SKIP_FRAMES=0: first Vsync rise arms FRAME.
- FRAME never returns to IDLE except by Reset.
- Byte phase toggles per accepted byte: phase 0 latches hi byte; phase 1 with lo byte emits pixel.
- Camera byte order: hi = {R4..R0, G5..G3}, lo = {G2..G0, B4..B0}.
- Mapping: Data_Out[4:0]=hi[7:3]; Data_Out[10:5]={hi[2:0],lo[7:5]}; Data_Out[15:11]=lo[4:0].
- pix_cnt counts emitted pixels in current line; pixels when pix_cnt == H_PIXELS dropped (no En_Out), Err set.
- Href fall: if phase==1 (odd byte) discard held byte, phase<=0, Err set; if pix_cnt != H_PIXELS Err set; if pix_cnt>0 line_cnt++; pix_cnt<=0.
- Lines accepted only while line_cnt < V_LINES; bytes of extra lines dropped, Err set.
- Frame_Done pulses the cycle after the Href fall that makes line_cnt == V_LINES.
- Vsync rise in FRAME: phase, pix_cnt, line_cnt cleared; if a frame was in progress (in_frame) and line_cnt != V_LINES, Frame_Done pulses and Err<=1 in that cycle; otherwise Err<=0. Set takes priority over clear.
- Vsync high with Href high: bytes ignored; the Href fall still performs line bookkeeping.
- Counters sized $clog2(H_PIXELS+1), $clog2(V_LINES+1), $clog2(SKIP_FRAMES+1) (min 1 bit).

## Timing

- Reset: state IDLE, all counters/phase/in_frame 0; En_Out, Data_Out=0x0000, Frame_Start, Frame_Done, Err all 0.
- Pixel latency: lo byte accepted at cycle t -> En_Out/Data_Out valid at t+1, registered.
- Back-to-back bytes every cycle supported: one pixel per two cycles max.
- Frame_Start asserts with En_Out of pixel 0 of line 0 only.
- Err rises the cycle after the offending event; stays high until next Vsync rise.
- Reset mid-line: all outputs 0 next cycle; skip counting restarts from 0.

## Test plan

- Colour mapping, SKIP_FRAMES=0: bytes (0xF8,0x00),(0x07,0xE0),(0x00,0x1F) -> Data_Out 0x001F, 0x07E0, 0xF800, each one cycle after lo byte; Frame_Start on first only.
- Skip: SKIP_FRAMES=2, H=4, V=2, three full frames -> En_Out only during third frame; exactly 8 strobes; Frame_Done once; Err 0.
- Short line: H=4, line with 6 bytes -> 3 pixels, Err=1 after Href fall; cleared at next Vsync rise if following frame clean.
- Odd byte / long line: 9 bytes on H=4 line -> 4 pixels, 9th discarded, Err=1; 10 bytes -> 4 pixels, 5th pixel dropped, Err=1.
- Short frame: V=2, Vsync rise after 1 line -> Frame_Done pulse at Vsync rise, Err=1 same cycle.
- Reset mid-frame after hi byte -> outputs 0; next lo byte ignored; operation resumes after SKIP_FRAMES+1 Vsync rises.
